sdram_pll_supervisor: RTL and testbench
=======================================

// Module: sdram_pll_supervisor
// PURPOSE
//  Lock supervisor and dynamic-phase-shift (DPS) sequencer for the SDRAM clock PLL, generalised to NUM_CLOCKS outputs.
//  Drives PLL reset, filters the lock indicator, then releases staggered per-domain resets.
//  Steps any output's phase at run time through the PLL phase_en/cntsel/updn/phase_done port.
//  Runs on the PLL reference clock. Sits between the board reset and the SDRAM controller / read-capture clock domains.
// PARAMETERS
//  NUM_CLOCKS     2     PLL outputs under control (1..18)
//  CNTSEL_W       5     width of PLL counter-select bus
//  STEP_W         8     signed width of step request and phase position
//  PLL_RST_CYC    16    cycles pll_rst is held high per attempt
//  LOCK_FILTER    1024  consecutive synced-locked cycles before lock is declared
//  LOCK_TIMEOUT   65536 cycles in WAIT_LOCK before a retry
//  RST_STAGGER    8     cycles between successive dom_rst_n releases
//  STEP_TIMEOUT   256   cycles allowed per phase_done handshake
// PORTS
//  refclk       in   1                    reference clock, sole clock
//  rst_n        in   1                    async active-low reset
//  pll_rst      out  1                    PLL reset, active high
//  pll_locked   in   1                    PLL locked, async (2-flop sync)
//  phase_en     out  1                    DPS step strobe
//  cntsel       out  CNTSEL_W             DPS counter select
//  updn         out  1                    DPS direction (1=up)
//  phase_done   in   1                    DPS done, async (2-flop sync)
//  req_valid    in   1                    phase request valid
//  req_ready    out  1                    phase request accepted
//  req_sel      in   CNTSEL_W             target output index
//  req_steps    in   STEP_W               signed step count, 0 = no-op
//  rsp_done     out  1                    one-cycle pulse, request finished
//  rsp_err      out  1                    qualifies rsp_done: timeout / abort / bad sel
//  lock_ok      out  1                    filtered lock
//  retry_cnt    out  8                    saturating relock attempts
//  dom_rst_n    out  NUM_CLOCKS           per-domain reset, bit i released i*RST_STAGGER after lock_ok
//  phase_pos    out  NUM_CLOCKS*STEP_W    net signed steps applied per output
// BEHAVIOUR
//  Reset values (rst_n low)
//   - pll_rst=1, everything else 0, FSM=PLL_RST.
//  FSM states
//   - PLL_RST: hold pll_rst PLL_RST_CYC cycles -> WAIT_LOCK.
//   - WAIT_LOCK: filter counter increments while synced lock=1 and clears on 0. Reaching LOCK_FILTER -> RUN.
//     LOCK_TIMEOUT expiry -> retry_cnt+1 (saturates at 255), then PLL_RST.
//   - RUN: lock_ok=1; stagger counter releases dom_rst_n LSB first; req_ready=1 only here.
//   - STEP: phase_en=1 for exactly one cycle, cntsel/updn stable -> DONE_WAIT.
//   - DONE_WAIT: wait synced phase_done 1->0->1.
//     Then phase_pos[sel] +/-1 (wraps two's-complement); remaining-1.
//     If remaining=0 -> rsp_done -> RUN, else -> STEP.
//     STEP_TIMEOUT expiry -> rsp_done+rsp_err, position keeps completed steps -> RUN.
//  Request acceptance
//   - Accept on req_valid&req_ready; latch sel, updn=~sign, remaining=|req_steps|.
//   - req_steps=0: rsp_done the next cycle, no PLL activity.
//   - req_sel>=NUM_CLOCKS: rsp_done+rsp_err the next cycle.
//   - Most-negative req_steps: magnitude uses STEP_W+1 bits, no overflow.
//  Loss of lock
//   - Synced lock=0 for 2 consecutive cycles in RUN/STEP/DONE_WAIT, same cycle:
//     lock_ok=0, all dom_rst_n=0, phase_pos cleared.
//   - An in-flight request ends with rsp_done+rsp_err; retry_cnt+1; -> PLL_RST.
//  Glitch filter
//   - A single-cycle lock drop does not trigger loss of lock.
//  Mid-operation reset
//   - rst_n low forces reset values asynchronously; deassertion is synchronised inside the block.
//  Outputs
//   - All outputs are registered; phase_en never asserts outside STEP.
// STRUCTURE
//  Package sdram_pll_pkg
//   - FSM state enum.
//   - Width localparams: counter width = $clog2 of largest cycle parameter.
//   - Helper: |signed| to unsigned.
//  Sub-module sdram_pll_sync2
//   - 2-flop synchroniser, instanced for pll_locked and phase_done.
//  All remaining logic lives in this file.
// TESTING
//  1 Lock path: locked rises 20 cycles after pll_rst falls (PLL_RST_CYC=16, LOCK_FILTER=1024)
//    -> lock_ok 1024+3 cycles later; dom_rst_n[0] next cycle, dom_rst_n[1] 8 cycles after that.
//  2 Relock: locked never rises (LOCK_TIMEOUT=4096) -> pll_rst re-pulses every 16+4096 cycles; retry_cnt 1,2,3.
//  3 Phase step: req sel=1, steps=-3; model phase_done low 2 / high on 5th cycle
//    -> 3 phase_en pulses, cntsel=1, updn=0; phase_pos[1]=-3; rsp_done, rsp_err=0.
//  4 Timeout: phase_done stuck high, steps=+2 -> one phase_en, rsp_err after 256 cycles; phase_pos unchanged.
//  5 Lock loss mid-step: drop locked 3 cycles during DONE_WAIT
//    -> rsp_done+rsp_err, dom_rst_n=0, phase_pos=0, PLL_RST; a 1-cycle drop is ignored.
//  6 Edge requests: steps=0 -> done next cycle, no phase_en; sel=5 -> rsp_err; steps=-128 -> 128 up-clears.

Source files
------------

// File: rtl/sdram_pll_pkg.sv
// Shared types and helpers for the SDRAM PLL lock supervisor and phase-step sequencer.
package sdram_pll_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_RUN,
    ST_STEP,
    ST_DONE_WAIT
  } pll_state_t;

  localparam int RETRY_W = 8;

  // Bits needed to hold the largest of the given cycle counts (inclusive).
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Magnitude of a signed value, one bit wider so the most-negative input cannot overflow.
  function automatic logic [32:0] abs_mag(input logic signed [31:0] v);
    logic signed [32:0] w;
    w = 33'(v);
    return w[32] ? -w : w;
  endfunction

endpackage

// File: rtl/sdram_pll_sync2.sv
// Two-flop synchroniser with asynchronous clear; also used as the reset-release bridge.
module sdram_pll_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      q        <= 1'b0;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/sdram_pll_supervisor.sv
// PLL lock supervisor: PLL reset/retry, lock filtering, staggered domain reset release
// and a request-driven dynamic-phase-shift sequencer for NUM_CLOCKS outputs.
module sdram_pll_supervisor
  import sdram_pll_pkg::*;
#(
  parameter int NUM_CLOCKS   = 2,
  parameter int CNTSEL_W     = 5,
  parameter int STEP_W       = 8,
  parameter int PLL_RST_CYC  = 16,
  parameter int LOCK_FILTER  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int RST_STAGGER  = 8,
  parameter int STEP_TIMEOUT = 256
) (
  input  logic                         refclk,
  input  logic                         rst_n,
  output logic                         pll_rst,
  input  logic                         pll_locked,
  output logic                         phase_en,
  output logic [CNTSEL_W-1:0]          cntsel,
  output logic                         updn,
  input  logic                         phase_done,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [CNTSEL_W-1:0]          req_sel,
  input  logic [STEP_W-1:0]            req_steps,
  output logic                         rsp_done,
  output logic                         rsp_err,
  output logic                         lock_ok,
  output logic [RETRY_W-1:0]           retry_cnt,
  output logic [NUM_CLOCKS-1:0]        dom_rst_n,
  output logic [NUM_CLOCKS*STEP_W-1:0] phase_pos
);

  localparam int CNT_W  = cnt_width(PLL_RST_CYC, LOCK_FILTER, LOCK_TIMEOUT, STEP_TIMEOUT);
  localparam int ST_MAX = (NUM_CLOCKS - 1) * RST_STAGGER;
  localparam int ST_W   = cnt_width(ST_MAX, 0, 0, 0);
  localparam int REM_W  = STEP_W + 1;
  localparam logic [CNTSEL_W:0] NUM_SEL = (CNTSEL_W + 1)'(NUM_CLOCKS);

  pll_state_t          state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    filt_reg;
  logic [ST_W-1:0]     st_reg;
  logic [REM_W-1:0]    rem_reg;
  logic [CNTSEL_W-1:0] sel_reg;
  logic [STEP_W-1:0]   pos_reg [NUM_CLOCKS];
  logic                seen_low_reg;
  logic                lock_prev_reg;
  logic                rst_n_s, lock_s, done_s;
  logic                running, lock_lost, req_fire, bad_sel;

  sdram_pll_sync2 u_rst_sync  (.clk(refclk), .rst_n(rst_n), .d(1'b1),       .q(rst_n_s));
  sdram_pll_sync2 u_lock_sync (.clk(refclk), .rst_n(rst_n), .d(pll_locked), .q(lock_s));
  sdram_pll_sync2 u_done_sync (.clk(refclk), .rst_n(rst_n), .d(phase_done), .q(done_s));

  assign running   = (state_reg == ST_RUN) || (state_reg == ST_STEP) || (state_reg == ST_DONE_WAIT);
  // Two consecutive low samples are required, so a one-cycle lock glitch is ignored.
  assign lock_lost = running && !lock_s && !lock_prev_reg;
  assign req_fire  = req_valid && req_ready;
  assign bad_sel   = {1'b0, req_sel} >= NUM_SEL;

  for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_pos
    assign phase_pos[gi*STEP_W +: STEP_W] = pos_reg[gi];
  end

  always_ff @(posedge refclk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_reg     <= ST_PLL_RST;
      pll_rst       <= 1'b1;
      phase_en      <= 1'b0;
      cntsel        <= '0;
      updn          <= 1'b0;
      req_ready     <= 1'b0;
      rsp_done      <= 1'b0;
      rsp_err       <= 1'b0;
      lock_ok       <= 1'b0;
      retry_cnt     <= '0;
      dom_rst_n     <= '0;
      cnt_reg       <= '0;
      filt_reg      <= '0;
      st_reg        <= '0;
      rem_reg       <= '0;
      sel_reg       <= '0;
      seen_low_reg  <= 1'b0;
      lock_prev_reg <= 1'b0;
      for (int i = 0; i < NUM_CLOCKS; i++) pos_reg[i] <= '0;
    end else begin
      lock_prev_reg <= lock_s;
      rsp_done      <= 1'b0;
      rsp_err       <= 1'b0;
      phase_en      <= 1'b0;
      if (lock_lost) begin
        // An accepted or in-flight request is closed with an error response.
        rsp_done  <= (state_reg != ST_RUN) || req_fire;
        rsp_err   <= (state_reg != ST_RUN) || req_fire;
        state_reg <= ST_PLL_RST;
        pll_rst   <= 1'b1;
        cnt_reg   <= '0;
        lock_ok   <= 1'b0;
        req_ready <= 1'b0;
        dom_rst_n <= '0;
        st_reg    <= '0;
        for (int i = 0; i < NUM_CLOCKS; i++) pos_reg[i] <= '0;
        if (retry_cnt != '1) retry_cnt <= retry_cnt + RETRY_W'(1);
      end else begin
        if (running) begin
          if (st_reg != ST_W'(ST_MAX)) st_reg <= st_reg + ST_W'(1);
          for (int i = 0; i < NUM_CLOCKS; i++)
            if (st_reg == ST_W'(i * RST_STAGGER)) dom_rst_n[i] <= 1'b1;
        end
        case (state_reg)
          ST_PLL_RST: begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(PLL_RST_CYC - 1)) begin
              state_reg <= ST_WAIT_LOCK;
              pll_rst   <= 1'b0;
              cnt_reg   <= '0;
              filt_reg  <= '0;
            end
          end
          ST_WAIT_LOCK: begin
            cnt_reg  <= cnt_reg + CNT_W'(1);
            filt_reg <= lock_s ? filt_reg + CNT_W'(1) : '0;
            if (filt_reg == CNT_W'(LOCK_FILTER)) begin
              state_reg <= ST_RUN;
              lock_ok   <= 1'b1;
              req_ready <= 1'b1;
              st_reg    <= '0;
            end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
              state_reg <= ST_PLL_RST;
              pll_rst   <= 1'b1;
              cnt_reg   <= '0;
              if (retry_cnt != '1) retry_cnt <= retry_cnt + RETRY_W'(1);
            end
          end
          ST_RUN: begin
            if (req_fire) begin
              if (bad_sel) begin
                rsp_done <= 1'b1;
                rsp_err  <= 1'b1;
              end else if (req_steps == '0) begin
                rsp_done <= 1'b1;
              end else begin
                sel_reg   <= req_sel;
                cntsel    <= req_sel;
                updn      <= ~req_steps[STEP_W-1];
                rem_reg   <= REM_W'(abs_mag(32'($signed(req_steps))));
                state_reg <= ST_STEP;
                phase_en  <= 1'b1;
                req_ready <= 1'b0;
              end
            end
          end
          ST_STEP: begin
            state_reg    <= ST_DONE_WAIT;
            cnt_reg      <= '0;
            seen_low_reg <= 1'b0;
          end
          ST_DONE_WAIT: begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            if (!done_s) seen_low_reg <= 1'b1;
            if (seen_low_reg && done_s) begin
              for (int i = 0; i < NUM_CLOCKS; i++)
                if (sel_reg == CNTSEL_W'(i))
                  pos_reg[i] <= updn ? pos_reg[i] + STEP_W'(1) : pos_reg[i] - STEP_W'(1);
              rem_reg <= rem_reg - REM_W'(1);
              if (rem_reg == REM_W'(1)) begin
                rsp_done  <= 1'b1;
                state_reg <= ST_RUN;
                req_ready <= 1'b1;
              end else begin
                state_reg <= ST_STEP;
                phase_en  <= 1'b1;
              end
            end else if (cnt_reg == CNT_W'(STEP_TIMEOUT - 1)) begin
              rsp_done  <= 1'b1;
              rsp_err   <= 1'b1;
              state_reg <= ST_RUN;
              req_ready <= 1'b1;
            end
          end
          default: begin
            state_reg <= ST_PLL_RST;
            pll_rst   <= 1'b1;
            cnt_reg   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_pll_supervisor.sv
// Randomised bench for sdram_pll_supervisor with a PLL/DPS port model and a positional reference model.
module tb_sdram_pll_supervisor;

  localparam int NC = 2, CW = 5, SW = 8, PRC = 16, LF = 1024, LT = 4096, RS = 8, STO = 256;

  logic refclk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_locked = 1'b0;
  logic phase_done = 1'b1;
  logic req_valid = 1'b0;
  logic [CW-1:0] req_sel = '0;
  logic [SW-1:0] req_steps = '0;
  logic pll_rst, phase_en, updn, req_ready, rsp_done, rsp_err, lock_ok;
  logic [CW-1:0] cntsel;
  logic [7:0] retry_cnt;
  logic [NC-1:0] dom_rst_n;
  logic [NC*SW-1:0] phase_pos;

  int n_tests = 0;
  int n_fail = 0;
  int pe_count = 0;
  logic [CW-1:0] pe_cntsel = '0;
  logic pe_updn = 1'b0;
  bit dps_stuck = 1'b0;
  logic signed [SW-1:0] exp_pos [NC];
  int exp_retry = 0;

  sdram_pll_supervisor #(
    .NUM_CLOCKS(NC), .CNTSEL_W(CW), .STEP_W(SW), .PLL_RST_CYC(PRC), .LOCK_FILTER(LF),
    .LOCK_TIMEOUT(LT), .RST_STAGGER(RS), .STEP_TIMEOUT(STO)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_rst(pll_rst), .pll_locked(pll_locked),
    .phase_en(phase_en), .cntsel(cntsel), .updn(updn), .phase_done(phase_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_steps(req_steps),
    .rsp_done(rsp_done), .rsp_err(rsp_err), .lock_ok(lock_ok), .retry_cnt(retry_cnt),
    .dom_rst_n(dom_rst_n), .phase_pos(phase_pos)
  );

  initial forever #5 refclk = ~refclk;

  // Phase-step strobe monitor.
  initial forever begin
    @(negedge refclk);
    if (phase_en === 1'b1) begin
      pe_count++;
      pe_cntsel = cntsel;
      pe_updn = updn;
    end
  end

  // PLL DPS port model: phase_done high, low for 2 cycles, high again on the 5th cycle.
  initial forever begin
    @(negedge refclk);
    if (phase_en === 1'b1 && !dps_stuck) begin
      repeat (2) @(posedge refclk);
      #1 phase_done = 1'b0;
      repeat (2) @(posedge refclk);
      #1 phase_done = 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic send_req(input int sel, input int steps, input int budget,
                          output bit done, output logic err, output int lat);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < budget) begin tick(); n++; end
    req_valid = 1'b1;
    req_sel = CW'(sel);
    req_steps = SW'(steps);
    tick();
    req_valid = 1'b0;
    done = 1'b0;
    err = 1'bx;
    lat = 1;
    while (lat <= budget) begin
      if (rsp_done === 1'b1) begin
        done = 1'b1;
        err = rsp_err;
        break;
      end
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NC; i++) exp_pos[i] = '0;
    exp_retry = 0;
    repeat (3) tick();
    n_tests++;
    if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst got %b required 1", pll_rst); end
    n_tests++;
    if ({phase_en, updn, req_ready, rsp_done, rsp_err, lock_ok} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b required 000000", {phase_en, updn, req_ready, rsp_done, rsp_err, lock_ok});
    end
    n_tests++;
    if ({cntsel, retry_cnt, dom_rst_n, phase_pos} !== '0) begin
      n_fail++;
      $display("FAIL reset_buses got cntsel=%0d retry=%0d dom=%b pos=%h required all 0", cntsel, retry_cnt, dom_rst_n, phase_pos);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_relock();
    int n;
    n = 0;
    while (pll_rst !== 1'b0 && n < 100) begin tick(); n++; end
    n_tests++;
    if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL relock_first_release got pll_rst=%b required 0", pll_rst); end
    for (int k = 1; k <= 3; k++) begin
      n = 0;
      while (pll_rst !== 1'b1 && n < LT + 100) begin tick(); n++; end
      exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
      n_tests++;
      if (n !== LT) begin n_fail++; $display("FAIL relock_wait[%0d] got %0d cycles required %0d", k, n, LT); end
      n_tests++;
      if (retry_cnt !== 8'(exp_retry)) begin n_fail++; $display("FAIL relock_retry[%0d] got %0d required %0d", k, retry_cnt, exp_retry); end
      n = 0;
      while (pll_rst !== 1'b0 && n < PRC + 100) begin tick(); n++; end
      n_tests++;
      if (n !== PRC) begin n_fail++; $display("FAIL relock_pulse[%0d] got %0d cycles required %0d", k, n, PRC); end
    end
  endtask

  task automatic test_midop_reset();
    @(posedge refclk);
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NC; i++) exp_pos[i] = '0;
    exp_retry = 0;
    n_tests++;
    if ({pll_rst, lock_ok, req_ready, retry_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      n_fail++;
      $display("FAIL midop_reset got pll_rst=%b lock_ok=%b ready=%b retry=%0d required 1 0 0 0", pll_rst, lock_ok, req_ready, retry_cnt);
    end
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_lock_path();
    int n;
    n = 0;
    while (pll_rst !== 1'b0 && n < 100) begin tick(); n++; end
    n_tests++;
    if (pll_rst !== 1'b0) begin n_fail++; $display("FAIL lock_pll_release got %b required 0", pll_rst); end
    repeat (20) tick();
    pll_locked = 1'b1;
    n = 0;
    while (lock_ok !== 1'b1 && n < LF + 100) begin tick(); n++; end
    n_tests++;
    if (n !== LF + 3) begin n_fail++; $display("FAIL lock_latency got %0d cycles required %0d", n, LF + 3); end
    n_tests++;
    if ({req_ready, dom_rst_n} !== {1'b1, 2'b00}) begin
      n_fail++;
      $display("FAIL lock_first_cycle got ready=%b dom=%b required 1 00", req_ready, dom_rst_n);
    end
    tick();
    n_tests++;
    if (dom_rst_n !== 2'b01) begin n_fail++; $display("FAIL dom0_release got %b required 01", dom_rst_n); end
    repeat (RS - 1) tick();
    n_tests++;
    if (dom_rst_n !== 2'b01) begin n_fail++; $display("FAIL dom1_early got %b required 01", dom_rst_n); end
    tick();
    n_tests++;
    if (dom_rst_n !== 2'b11) begin n_fail++; $display("FAIL dom1_release got %b required 11", dom_rst_n); end
  endtask

  task automatic test_phase_step();
    int sel, s, pe0, lat;
    bit done;
    logic err;
    dps_stuck = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (r == 0) begin
        sel = 1;
        s = -3;
      end else begin
        sel = int'($urandom_range(0, NC - 1));
        s = int'($urandom_range(0, 12)) - 6;
        if (s == 0) s = 2;
      end
      pe0 = pe_count;
      send_req(sel, s, 400, done, err, lat);
      exp_pos[sel] = exp_pos[sel] + SW'(s);
      n_tests++;
      if (done !== 1'b1 || err !== 1'b0) begin
        n_fail++;
        $display("FAIL step_rsp[%0d] got done=%b err=%b required 1 0", r, done, err);
      end
      n_tests++;
      if (pe_count - pe0 !== iabs(s)) begin
        n_fail++;
        $display("FAIL step_pulses[%0d] got %0d required %0d", r, pe_count - pe0, iabs(s));
      end
      n_tests++;
      if (pe_cntsel !== CW'(sel) || pe_updn !== (s > 0)) begin
        n_fail++;
        $display("FAIL step_dir[%0d] got cntsel=%0d updn=%b required %0d %b", r, pe_cntsel, pe_updn, sel, s > 0);
      end
      n_tests++;
      if (phase_pos[sel*SW +: SW] !== exp_pos[sel]) begin
        n_fail++;
        $display("FAIL step_pos[%0d] got %0d required %0d", r, $signed(phase_pos[sel*SW +: SW]), exp_pos[sel]);
      end
    end
  endtask

  task automatic test_timeout();
    int pe0, lat;
    bit done;
    logic err;
    dps_stuck = 1'b1;
    pe0 = pe_count;
    send_req(0, 2, STO + 50, done, err, lat);
    n_tests++;
    if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL timeout_rsp got done=%b err=%b required 1 1", done, err); end
    n_tests++;
    if (lat < STO || lat > STO + 3) begin n_fail++; $display("FAIL timeout_latency got %0d required %0d..%0d", lat, STO, STO + 3); end
    n_tests++;
    if (pe_count - pe0 !== 1) begin n_fail++; $display("FAIL timeout_pulses got %0d required 1", pe_count - pe0); end
    n_tests++;
    if (phase_pos[0 +: SW] !== exp_pos[0]) begin
      n_fail++;
      $display("FAIL timeout_pos got %0d required %0d", $signed(phase_pos[0 +: SW]), exp_pos[0]);
    end
    dps_stuck = 1'b0;
  endtask

  task automatic test_edge_requests();
    int pe0, lat;
    bit done;
    logic err;
    pe0 = pe_count;
    send_req(1, 0, 20, done, err, lat);
    n_tests++;
    if (done !== 1'b1 || lat !== 1 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_steps got done=%b lat=%0d err=%b required 1 1 0", done, lat, err);
    end
    tick();
    n_tests++;
    if (rsp_done !== 1'b0) begin n_fail++; $display("FAIL zero_pulse_width got rsp_done=%b required 0", rsp_done); end
    send_req(5, 3, 20, done, err, lat);
    n_tests++;
    if (done !== 1'b1 || lat !== 1 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_sel got done=%b lat=%0d err=%b required 1 1 1", done, lat, err);
    end
    n_tests++;
    if (pe_count - pe0 !== 0 || phase_pos !== {exp_pos[1], exp_pos[0]}) begin
      n_fail++;
      $display("FAIL edge_no_activity got pulses=%0d pos=%h required 0 %h", pe_count - pe0, phase_pos, {exp_pos[1], exp_pos[0]});
    end
    pe0 = pe_count;
    send_req(0, -128, 3000, done, err, lat);
    exp_pos[0] = exp_pos[0] + SW'(-128);
    n_tests++;
    if (done !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL neg_max_rsp got done=%b err=%b required 1 0", done, err); end
    n_tests++;
    if (pe_count - pe0 !== 128 || pe_updn !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_max_pulses got %0d updn=%b required 128 0", pe_count - pe0, pe_updn);
    end
    n_tests++;
    if (phase_pos[0 +: SW] !== exp_pos[0]) begin
      n_fail++;
      $display("FAIL neg_max_pos got %0d required %0d", $signed(phase_pos[0 +: SW]), exp_pos[0]);
    end
  endtask

  task automatic test_lock_loss();
    int n, pe0;
    bit bad, done;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (lock_ok !== 1'b1 || pll_rst !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL glitch_ignored got lock disturbed=%b required 0", bad); end
    dps_stuck = 1'b1;
    pe0 = pe_count;
    req_valid = 1'b1;
    req_sel = CW'(1);
    req_steps = SW'(5);
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (pe_count - pe0 !== 1) begin n_fail++; $display("FAIL loss_in_step got pulses=%0d required 1", pe_count - pe0); end
    pll_locked = 1'b0;
    n = 0;
    done = 1'b0;
    while (n < 12) begin
      tick();
      n++;
      if (n == 3) pll_locked = 1'b1;
      if (rsp_done === 1'b1) begin done = 1'b1; break; end
    end
    pll_locked = 1'b1;
    exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
    n_tests++;
    if (done !== 1'b1 || rsp_err !== 1'b1) begin n_fail++; $display("FAIL loss_rsp got done=%b err=%b required 1 1", done, rsp_err); end
    n_tests++;
    if ({lock_ok, pll_rst, req_ready, dom_rst_n, phase_pos} !== {1'b0, 1'b1, 1'b0, 2'b00, 16'h0000}) begin
      n_fail++;
      $display("FAIL loss_state got lock_ok=%b pll_rst=%b ready=%b dom=%b pos=%h required 0 1 0 00 0000", lock_ok, pll_rst, req_ready, dom_rst_n, phase_pos);
    end
    n_tests++;
    if (retry_cnt !== 8'(exp_retry)) begin n_fail++; $display("FAIL loss_retry got %0d required %0d", retry_cnt, exp_retry); end
    dps_stuck = 1'b0;
  endtask

  initial begin
    test_reset();
    test_relock();
    test_midop_reset();
    test_lock_path();
    test_phase_step();
    test_timeout();
    test_edge_requests();
    test_lock_loss();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
